uart_boot_loader: RTL and testbench

Downstream consumer of the UART receiver's byte stream. It parses a framed program-load protocol, assembles little-endian 32-bit words, and writes them into the processor's instruction memory. It holds the CPU in reset while a load is in progress. It sits between the UART receiver (byte + one-cycle done strobe) and the instruction-memory write port of the single-cycle RISC-V core.

---
 rtl/uart_loader_pkg.sv | 17 +
 rtl/uart_boot_loader_byte_timeout.sv | 31 +++
 rtl/uart_boot_loader.sv | 133 +++++++++++++
 tb/tb_uart_boot_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM states, frame header
// and the 16-bit word-count type.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK
  } state_t;

  localparam logic [7:0] HEADER = 8'hA5;

  typedef logic [15:0] len_t;

endpackage

// File: rtl/uart_boot_loader_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while a frame is open and flags
// expiry once the gap since the last received byte reaches TIMEOUT cycles.
module byte_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  // Saturates at LIMIT so a stalled frame cannot wrap back into "not expired".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/uart_boot_loader.sv
// Parses A5 / N_lo / N_hi / 4*N data / XOR-checksum frames from the UART
// receiver and writes little-endian words into instruction memory.
module uart_boot_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_error
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [16:0] MAX_WORDS = 17'(DEPTH - BASE_ADDR);

  state_t      state;
  len_t        n_len;
  len_t        word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  checksum;
  logic        expired;

  assign busy = (state != ST_IDLE);

  byte_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid),
    .enable  (busy),
    .expired (expired)
  );

  // A received byte always takes priority over a timeout in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      n_len      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      checksum   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;

      if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_byte == HEADER) begin
              state    <= ST_LEN_LO;
              cpu_hold <= 1'b1;
              checksum <= '0;
              word_idx <= '0;
              byte_idx <= '0;
            end
          end

          ST_LEN_LO: begin
            n_len[7:0] <= rx_byte;
            state      <= ST_LEN_HI;
          end

          ST_LEN_HI: begin
            n_len[15:8] <= rx_byte;
            if ({1'b0, rx_byte, n_len[7:0]} > MAX_WORDS) begin
              state      <= ST_IDLE;
              load_error <= 1'b1;
            end else if ({rx_byte, n_len[7:0]} == 16'd0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_DATA;
            end
          end

          ST_DATA: begin
            checksum <= checksum ^ rx_byte;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_byte;
              2'd1: word_buf[15:8]  <= rx_byte;
              2'd2: word_buf[23:16] <= rx_byte;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= ADDR_W'(BASE_ADDR + int'(word_idx));
                mem_wdata <= {rx_byte, word_buf};
                word_idx  <= word_idx + 16'd1;
                if (word_idx == n_len - 16'd1) begin
                  state <= ST_CHECK;
                end
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end

          ST_CHECK: begin
            state <= ST_IDLE;
            if (rx_byte == checksum) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end else if (expired) begin
        state      <= ST_IDLE;
        load_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected writes and done/error events
// are queued as bytes are driven and matched by a negedge monitor.
module tb_uart_boot_loader;

  localparam int ADDR_W = 10;
  localparam int TOUT   = 40;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_byte = 8'h00;
  logic              rx_valid = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              load_done;
  logic              load_error;

  int n_checks = 0;
  int n_fails  = 0;

  logic [ADDR_W+31:0] exp_wr[$];
  int                 exp_ev[$];

  uart_boot_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0),
    .TIMEOUT   (TOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every write and every done/error pulse must be expected.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        n_checks++;
        if (exp_wr.size() == 0) begin
          n_fails++;
          $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, want no write", mem_addr, mem_wdata);
        end else begin
          logic [ADDR_W+31:0] e;
          e = exp_wr.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            n_fails++;
            $display("[TB] FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                     mem_addr, mem_wdata, e[ADDR_W+31:32], e[31:0]);
          end
        end
      end
      if (load_done && load_error) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL done_and_error: got both high, want at most one");
      end else if (load_done || load_error) begin
        int got;
        got = load_done ? EV_DONE : EV_ERR;
        n_checks++;
        if (exp_ev.size() == 0) begin
          n_fails++;
          $display("[TB] FAIL unexpected_event: got %0d, want none", got);
        end else begin
          int want;
          want = exp_ev.pop_front();
          if (got !== want) begin
            n_fails++;
            $display("[TB] FAIL event: got %0d, want %0d (1=done 2=error)", got, want);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1, input bit bad);
    logic [7:0]  ck;
    logic [31:0] w;
    ck = 8'h00;
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      exp_wr.push_back({ADDR_W'(i), w});
      ck = ck ^ xor4(w);
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
    end
    exp_ev.push_back(bad ? EV_ERR : EV_DONE);
    send_byte(bad ? (ck ^ 8'h01) : ck);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (exp_wr.size() != 0 || exp_ev.size() != 0); i++)
      @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_we, cpu_hold, busy, load_done, load_error} !== 5'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_flags: got %b, want 00000", {mem_we, cpu_hold, busy, load_done, load_error});
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== '0) begin
      n_fails++;
      $display("[TB] FAIL reset_mem: got addr=%0d data=%h, want 0/0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word;
    send_byte(8'hA5);
    n_checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL header_hold: got hold=%b busy=%b, want 1/1", cpu_hold, busy);
    end
    send_byte(8'h01); send_byte(8'h00);
    exp_wr.push_back({ADDR_W'(0), 32'h12345678});
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    exp_ev.push_back(EV_DONE);
    send_byte(8'h08);
    n_checks++;
    if (cpu_hold !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL single_release: got hold=%b busy=%b, want 0/0", cpu_hold, busy);
    end
    drain(4);
    n_checks++;
    if (exp_wr.size() + exp_ev.size() !== 0) begin
      n_fails++;
      $display("[TB] FAIL single_pending: got %0d outstanding, want 0", exp_wr.size() + exp_ev.size());
    end
  endtask

  task automatic test_bad_checksum;
    send_frame(1, 32'h12345678, 32'h0, 1'b1);
    n_checks++;
    if (cpu_hold !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL bad_ck_hold: got %b, want 1", cpu_hold);
    end
    send_frame(1, 32'hDEADBEEF, 32'h0, 1'b0);
    drain(4);
    n_checks++;
    if (cpu_hold !== 1'b0 || exp_wr.size() + exp_ev.size() !== 0) begin
      n_fails++;
      $display("[TB] FAIL bad_ck_recover: got hold=%b pending=%0d, want 0/0", cpu_hold, exp_wr.size() + exp_ev.size());
    end
  endtask

  task automatic test_length_bounds;
    send_frame(0, 32'h0, 32'h0, 1'b0);
    send_byte(8'hA5); send_byte(8'h01);
    exp_ev.push_back(EV_ERR);
    send_byte(8'h04);
    n_checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL too_long_state: got busy=%b hold=%b, want 0/1", busy, cpu_hold);
    end
    drain(4);
    n_checks++;
    if (exp_wr.size() + exp_ev.size() !== 0) begin
      n_fails++;
      $display("[TB] FAIL length_pending: got %0d outstanding, want 0", exp_wr.size() + exp_ev.size());
    end
  endtask

  task automatic test_timeout;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h78);
    repeat (TOUT) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL timeout_early: got busy=%b, want 1", busy);
    end
    exp_ev.push_back(EV_ERR);
    drain(5);
    n_checks++;
    if (exp_ev.size() !== 0 || busy !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL timeout_expire: got pending=%0d busy=%b, want 0/0", exp_ev.size(), busy);
    end
    // Byte arriving exactly on the expiry cycle must keep the frame alive.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    repeat (TOUT) @(negedge clk);
    exp_wr.push_back({ADDR_W'(0), 32'h0BADF00D});
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hAD); send_byte(8'h0B);
    exp_ev.push_back(EV_DONE);
    send_byte(xor4(32'h0BADF00D));
    drain(4);
    n_checks++;
    if (cpu_hold !== 1'b0 || exp_wr.size() + exp_ev.size() !== 0) begin
      n_fails++;
      $display("[TB] FAIL timeout_recover: got hold=%b pending=%0d, want 0/0", cpu_hold, exp_wr.size() + exp_ev.size());
    end
  endtask

  task automatic test_back_to_back;
    send_byte(8'h3C); send_byte(8'hFF);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL junk_ignored: got busy=%b, want 0", busy);
    end
    send_frame(2, 32'hA1B2C3D4, 32'h55667788, 1'b0);
    drain(4);
    n_checks++;
    if (exp_wr.size() + exp_ev.size() !== 0) begin
      n_fails++;
      $display("[TB] FAIL b2b_pending: got %0d outstanding, want 0", exp_wr.size() + exp_ev.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    exp_wr.push_back({ADDR_W'(0), 32'h44332211});
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h99); send_byte(8'h98);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_we, cpu_hold, busy, load_done, load_error} !== 5'b0 || mem_addr !== '0) begin
      n_fails++;
      $display("[TB] FAIL mid_reset: got flags=%b addr=%0d, want 0/0",
               {mem_we, cpu_hold, busy, load_done, load_error}, mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_frame(1, 32'hCAFEF00D, 32'h0, 1'b0);
    drain(4);
    n_checks++;
    if (cpu_hold !== 1'b0 || exp_wr.size() + exp_ev.size() !== 0) begin
      n_fails++;
      $display("[TB] FAIL after_reset: got hold=%b pending=%0d, want 0/0", cpu_hold, exp_wr.size() + exp_ev.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bad_checksum();
    test_length_bounds();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
